// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port main-memory arbiter.
// Policy macro used by the arbiter files: MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    ARB   = 2'd0,  // idle, choosing the next owner
    REQ   = 2'd1,  // request beat presented to memory
    WDATA = 2'd2,  // write-data beat presented to memory
    RRESP = 2'd3   // collecting refill beats for a read
  } arb_state_t;

  // Owner of the memory port.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    IC   = 2'd1,
    DC   = 2'd2
  } grant_t;

  localparam int DEF_MEM_ADDR_BITS = 28;
  localparam int DEF_MEM_DATA_BITS = 128;
  localparam int DEF_READ_BEATS    = 4;

  // Counter width for a given number of read beats (never zero).
  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational two-way winner selection for the memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN defined: ties go to the port not granted last.
// MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, DC wins every tie.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic       i_ic_valid,
  input  logic       i_dc_valid,
  input  logic [1:0] i_last_grant,
  output logic [1:0] o_winner
);

  // Pick at most one requester; NONE when nobody is asking.
  always_comb begin
    o_winner = NONE;
    if (i_ic_valid && i_dc_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      o_winner = (i_last_grant == IC) ? DC : IC;
`else
      o_winner = DC;
`endif
    end else if (i_ic_valid) begin
      o_winner = IC;
    end else if (i_dc_valid) begin
      o_winner = DC;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history; keep the port for a uniform interface.
  logic w_unused_last;
  assign w_unused_last = ^i_last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the instruction cache (IC) and the
// data cache (DC). One owner holds the port for a whole transaction:
// request + one write-data beat, or request + READ_BEATS refill beats.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking (see picker).
//
// Handshakes: a beat transfers in the cycle where its valid and ready are
// both high at the rising clock edge. Requesters hold valid (and fields)
// stable until they see ready; ready never depends on anything other than
// the registered owner and the matching memory-side ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  MEM_ADDR_BITS = DEF_MEM_ADDR_BITS,
  parameter int  MEM_DATA_BITS = DEF_MEM_DATA_BITS,
  parameter int  READ_BEATS    = DEF_READ_BEATS,
  localparam int MASK_BITS     = MEM_DATA_BITS / 8,
  localparam int BEAT_W        = beat_cnt_width(READ_BEATS)
) (
  input  logic                     clk,
  input  logic                     reset,
  // instruction cache port
  input  logic                     ic_mem_req_valid,
  output logic                     ic_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] ic_mem_req_addr,
  input  logic                     ic_mem_req_rw,
  input  logic                     ic_mem_req_data_valid,
  output logic                     ic_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] ic_mem_req_data_bits,
  input  logic [MASK_BITS-1:0]     ic_mem_req_data_mask,
  output logic                     ic_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] ic_mem_resp_data,
  // data cache port
  input  logic                     dc_mem_req_valid,
  output logic                     dc_mem_req_ready,
  input  logic [MEM_ADDR_BITS-1:0] dc_mem_req_addr,
  input  logic                     dc_mem_req_rw,
  input  logic                     dc_mem_req_data_valid,
  output logic                     dc_mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] dc_mem_req_data_bits,
  input  logic [MASK_BITS-1:0]     dc_mem_req_data_mask,
  output logic                     dc_mem_resp_valid,
  output logic [MEM_DATA_BITS-1:0] dc_mem_resp_data,
  // memory side
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_req_rw,
  output logic                     mem_req_data_valid,
  input  logic                     mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0]     mem_req_data_mask,
  input  logic                     mem_resp_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_resp_data,
  // observation of internal state
  output logic [1:0]               o_dbg_state,
  output logic [1:0]               o_dbg_grant,
  output logic [BEAT_W-1:0]        o_dbg_beat_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  grant_t              r_grant;
  grant_t              w_grant_nxt;
  logic                r_rw;
  logic                w_rw_nxt;
  logic [BEAT_W-1:0]   r_beat;
  logic [BEAT_W-1:0]   w_beat_nxt;
  grant_t              w_last_nxt;
  logic [1:0]          w_last_for_pick;
  logic [1:0]          w_winner;

  logic                     w_ic_own;
  logic                     w_dc_own;
  logic                     w_sel_valid;
  logic [MEM_ADDR_BITS-1:0] w_sel_addr;
  logic                     w_sel_rw;
  logic                     w_sel_data_valid;
  logic [MEM_DATA_BITS-1:0] w_sel_data_bits;
  logic [MASK_BITS-1:0]     w_sel_data_mask;

  // Owner decode and field mux, straight from the registered grant.
  assign w_ic_own         = (r_grant == IC);
  assign w_dc_own         = (r_grant == DC);
  assign w_sel_valid      = w_ic_own ? ic_mem_req_valid      : dc_mem_req_valid;
  assign w_sel_addr       = w_ic_own ? ic_mem_req_addr       : dc_mem_req_addr;
  assign w_sel_rw         = w_ic_own ? ic_mem_req_rw         : dc_mem_req_rw;
  assign w_sel_data_valid = w_ic_own ? ic_mem_req_data_valid : dc_mem_req_data_valid;
  assign w_sel_data_bits  = w_ic_own ? ic_mem_req_data_bits  : dc_mem_req_data_bits;
  assign w_sel_data_mask  = w_ic_own ? ic_mem_req_data_mask  : dc_mem_req_data_mask;

  // Response data is broadcast; only the valids are steered.
  assign ic_mem_resp_data = mem_resp_data;
  assign dc_mem_resp_data = mem_resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_t r_last;

  // Last completed owner; moves only when a transaction finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= DC;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  assign w_last_for_pick = r_last;
`else
  // Fixed priority keeps no history.
  assign w_last_for_pick = DC;
`endif

  mem_arb_picker u_picker (
    .i_ic_valid   (ic_mem_req_valid),
    .i_dc_valid   (dc_mem_req_valid),
    .i_last_grant (w_last_for_pick),
    .o_winner     (w_winner)
  );

  // State, owner, direction and beat count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB;
      r_grant <= NONE;
      r_rw    <= 1'b0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_rw    <= w_rw_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next-state logic and per-phase routing of valids, readies and fields.
  always_comb begin
    w_state_nxt           = r_state;
    w_grant_nxt           = r_grant;
    w_rw_nxt              = r_rw;
    w_beat_nxt            = r_beat;
    w_last_nxt            = grant_t'(w_last_for_pick);
    ic_mem_req_ready      = 1'b0;
    dc_mem_req_ready      = 1'b0;
    ic_mem_req_data_ready = 1'b0;
    dc_mem_req_data_ready = 1'b0;
    ic_mem_resp_valid     = 1'b0;
    dc_mem_resp_valid     = 1'b0;
    mem_req_valid         = 1'b0;
    mem_req_addr          = '0;
    mem_req_rw            = 1'b0;
    mem_req_data_valid    = 1'b0;
    mem_req_data_bits     = '0;
    mem_req_data_mask     = '0;

    case (r_state)
      ARB: begin
        // Nothing is routed while idle; latch the winner and its direction.
        if (w_winner != NONE) begin
          w_state_nxt = REQ;
          w_grant_nxt = grant_t'(w_winner);
          w_rw_nxt    = (w_winner == IC) ? ic_mem_req_rw : dc_mem_req_rw;
        end
      end

      REQ: begin
        mem_req_valid    = w_sel_valid;
        mem_req_addr     = w_sel_addr;
        mem_req_rw       = w_sel_rw;
        ic_mem_req_ready = w_ic_own & mem_req_ready;
        dc_mem_req_ready = w_dc_own & mem_req_ready;
        // A dropped valid just stalls here; the grant is kept.
        if (w_sel_valid && mem_req_ready) begin
          w_state_nxt = r_rw ? WDATA : RRESP;
          w_beat_nxt  = '0;
        end
      end

      WDATA: begin
        mem_req_data_valid    = w_sel_data_valid;
        mem_req_data_bits     = w_sel_data_bits;
        mem_req_data_mask     = w_sel_data_mask;
        ic_mem_req_data_ready = w_ic_own & mem_req_data_ready;
        dc_mem_req_data_ready = w_dc_own & mem_req_data_ready;
        if (w_sel_data_valid && mem_req_data_ready) begin
          w_state_nxt = ARB;
          w_grant_nxt = NONE;
          w_last_nxt  = r_grant;
        end
      end

      RRESP: begin
        ic_mem_resp_valid = w_ic_own & mem_resp_valid;
        dc_mem_resp_valid = w_dc_own & mem_resp_valid;
        if (mem_resp_valid) begin
          if (r_beat == LAST_BEAT) begin
            w_beat_nxt  = '0;
            w_state_nxt = ARB;
            w_grant_nxt = NONE;
            w_last_nxt  = r_grant;
          end else begin
            w_beat_nxt = r_beat + BEAT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ARB;
        w_grant_nxt = NONE;
      end
    endcase
  end

  assign o_dbg_state    = r_state;
  assign o_dbg_grant    = r_grant;
  assign o_dbg_beat_cnt = r_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases followed by two
// randomized cache agents against a transaction-level reference model.
// Build with MEM_ARB_ROUND_ROBIN_EN to match a round-robin DUT.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam int NB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // requester-side drives, index 0 = IC, 1 = DC
  logic          a_valid [2];
  logic [AW-1:0] a_addr  [2];
  logic          a_rw    [2];
  logic          a_dv    [2];
  logic [DW-1:0] a_data  [2];
  logic [MW-1:0] a_mask  [2];

  logic ic_mem_req_ready, dc_mem_req_ready;
  logic ic_mem_req_data_ready, dc_mem_req_data_ready;
  logic ic_mem_resp_valid, dc_mem_resp_valid;
  logic [DW-1:0] ic_mem_resp_data, dc_mem_resp_data;
  logic mem_req_valid, mem_req_rw, mem_req_data_valid;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data_bits;
  logic [MW-1:0] mem_req_data_mask;
  logic mem_req_ready, mem_req_data_ready, mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic [1:0] o_dbg_state, o_dbg_grant;
  logic [1:0] o_dbg_beat_cnt;

  mem_arbiter dut (
    .clk(clk), .reset(rst),
    .ic_mem_req_valid(a_valid[0]), .ic_mem_req_ready(ic_mem_req_ready),
    .ic_mem_req_addr(a_addr[0]), .ic_mem_req_rw(a_rw[0]),
    .ic_mem_req_data_valid(a_dv[0]), .ic_mem_req_data_ready(ic_mem_req_data_ready),
    .ic_mem_req_data_bits(a_data[0]), .ic_mem_req_data_mask(a_mask[0]),
    .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
    .dc_mem_req_valid(a_valid[1]), .dc_mem_req_ready(dc_mem_req_ready),
    .dc_mem_req_addr(a_addr[1]), .dc_mem_req_rw(a_rw[1]),
    .dc_mem_req_data_valid(a_dv[1]), .dc_mem_req_data_ready(dc_mem_req_data_ready),
    .dc_mem_req_data_bits(a_data[1]), .dc_mem_req_data_mask(a_mask[1]),
    .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .o_dbg_state(o_dbg_state), .o_dbg_grant(o_dbg_grant), .o_dbg_beat_cnt(o_dbg_beat_cnt)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hs_now();
    return {mem_req_valid, mem_req_data_valid, ic_mem_req_ready, dc_mem_req_ready,
            ic_mem_req_data_ready, dc_mem_req_data_ready, ic_mem_resp_valid, dc_mem_resp_valid};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r = old_d;
    for (int i = 0; i < MW; i++) if (m[i]) r[i*8 +: 8] = new_d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // memory contents as seen by the memory model, and as the agents expect them
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] shadow  [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : '0;
  endfunction
  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : '0;
  endfunction

  // ---------------- reference model (transaction level) ----------------
  // One transaction at a time owns the port: request, then one data beat
  // for a write or NB response beats for a read.
  int m_active = 0, m_owner = 0, m_rw = 0, m_acc = 0, m_left = 0, m_last = 1;

  initial begin
    forever begin
      logic [7:0] e;
      @(negedge clk);
      e = '0;
      if (rst === 1'b1) begin
        check("rst_outputs", hs_now(), '0);
        m_active = 0;
        m_last   = 1;
      end else if (!m_active) begin
        check("idle_hs", hs_now(), '0);
        check("idle_fields", {mem_req_addr, mem_req_rw, mem_req_data_mask}, '0);
        check("idle_data", mem_req_data_bits, '0);
        if (a_valid[0] || a_valid[1]) begin
          if (a_valid[0] && a_valid[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_owner = (m_last == 0) ? 1 : 0;
`else
            m_owner = 1;
`endif
          end else begin
            m_owner = a_valid[0] ? 0 : 1;
          end
          m_active = 1;
          m_acc    = 0;
          m_rw     = int'(a_rw[m_owner]);
        end
      end else if (!m_acc) begin
        e[7] = a_valid[m_owner];
        e[5 - m_owner] = mem_req_ready;
        check("req_hs", hs_now(), e);
        check("req_addr", mem_req_addr, a_addr[m_owner]);
        check("req_rw", mem_req_rw, a_rw[m_owner]);
        if (a_valid[m_owner] && mem_req_ready) begin
          m_acc  = 1;
          m_left = m_rw ? 1 : NB;
        end
      end else if (m_rw != 0) begin
        e[6] = a_dv[m_owner];
        e[3 - m_owner] = mem_req_data_ready;
        check("wdata_hs", hs_now(), e);
        if (a_dv[m_owner]) begin
          check("wdata_bits", mem_req_data_bits, a_data[m_owner]);
          check("wdata_mask", mem_req_data_mask, a_mask[m_owner]);
          if (mem_req_data_ready) begin
            m_active = 0;
            m_last   = m_owner;
          end
        end
      end else begin
        e[1 - m_owner] = mem_resp_valid;
        check("rresp_hs", hs_now(), e);
        if (mem_resp_valid) begin
          m_left--;
          if (m_left == 0) begin
            m_active = 0;
            m_last   = m_owner;
          end
        end
      end
    end
  end

  // ---------------- memory model ----------------
  bit            mem_auto = 0;
  bit            resp_real = 0;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] pend [$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || !mem_auto) begin
        pend.delete();
        resp_real = 0;
      end else begin
        if (mem_resp_valid && resp_real) void'(pend.pop_front());
        if (mem_req_valid && mem_req_ready) begin
          cur_addr = mem_req_addr;
          if (!mem_req_rw)
            for (int k = 0; k < NB; k++) pend.push_back(mem_rd(mem_req_addr + AW'(k)));
        end
        if (mem_req_data_valid && mem_req_data_ready)
          mem_arr[cur_addr] = merge(mem_rd(cur_addr), mem_req_data_bits, mem_req_data_mask);
      end
      @(posedge clk);
      #1;
      if (mem_auto) begin
        mem_req_ready      = ($urandom_range(0, 3) != 0);
        mem_req_data_ready = ($urandom_range(0, 3) != 0);
        if (pend.size() > 0) begin
          mem_resp_valid = ($urandom_range(0, 2) != 0);
          mem_resp_data  = pend[0];
          resp_real      = 1;
        end else begin
          mem_resp_valid = ($urandom_range(0, 7) == 0);
          mem_resp_data  = rand_word();
          resp_real      = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 0; a_addr[i] = '0; a_rw[i] = 0;
      a_dv[i] = 0; a_data[i] = '0; a_mask[i] = '0;
    end
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic reset_dut();
    rst = 1;
    idle_all();
    repeat (2) tick();
    rst = 0;
  endtask

  function automatic logic port_sig(input int who, input int kind);
    case (kind)
      0:       return who == 0 ? ic_mem_req_ready      : dc_mem_req_ready;
      1:       return who == 0 ? ic_mem_req_data_ready : dc_mem_req_data_ready;
      default: return who == 0 ? ic_mem_resp_valid     : dc_mem_resp_valid;
    endcase
  endfunction

  // Wait (bounded) for a ready of the given kind; returns after the edge that transfers.
  task automatic wait_ready(input int who, input int kind, output bit got);
    int c = 0;
    got = 0;
    while (!got && c < 400) begin
      @(negedge clk);
      got = port_sig(who, kind);
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic run_agent(input int who, input int n_txn);
    logic [AW-1:0] base;
    logic [AW-1:0] addr;
    logic          rw;
    bit            got;
    int            beats;
    int            c;
    base = (who == 0) ? 28'h0000000 : 28'h1000000;
    for (int t = 0; t < n_txn; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      rw   = ($urandom_range(0, 1) == 1);
      addr = base + AW'($urandom_range(0, 7) * 4);
      if (rw) addr = addr + AW'($urandom_range(0, 3));
      a_valid[who] = 1; a_addr[who] = addr; a_rw[who] = rw;
      wait_ready(who, 0, got);
      a_valid[who] = 0;
      check("agent_req_done", got, 1);
      if (!got) return;
      if (rw) begin
        repeat ($urandom_range(0, 2)) tick();
        a_dv[who] = 1; a_data[who] = rand_word(); a_mask[who] = MW'($urandom);
        wait_ready(who, 1, got);
        check("agent_wdata_done", got, 1);
        if (got) shadow[addr] = merge(shadow_rd(addr), a_data[who], a_mask[who]);
        a_dv[who] = 0;
        if (!got) return;
      end else begin
        beats = 0;
        c = 0;
        while (beats < NB && c < 400) begin
          @(negedge clk);
          if (port_sig(who, 2)) begin
            check("agent_rd_data", who == 0 ? ic_mem_resp_data : dc_mem_resp_data,
                  shadow_rd(addr + AW'(beats)));
            beats++;
          end
          c++;
        end
        check("agent_rd_beats", beats, NB);
        if (beats != NB) return;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]   tie_exp_dc;
    logic [DW-1:0] wdat;
    bit           found;
    int           c;

    rst = 0;
    idle_all();
    #1 rst = 1;
    #1;
    check("reset_state", o_dbg_state, ARB);
    check("reset_grant", o_dbg_grant, NONE);
    check("reset_beat", o_dbg_beat_cnt, 0);
    check("reset_hs", hs_now(), '0);
    repeat (2) tick();
    rst = 0;

    // IC read alone
    a_valid[0] = 1; a_addr[0] = 28'h0000123; a_rw[0] = 0; mem_req_ready = 1;
    @(negedge clk);
    check("icrd_arb_cycle", mem_req_valid, 0);
    tick();
    @(negedge clk);
    check("icrd_latency", mem_req_valid, 1);
    check("icrd_addr", mem_req_addr, 28'h0000123);
    check("icrd_ready", ic_mem_req_ready, 1);
    tick();
    a_valid[0] = 0; mem_req_ready = 0;
    for (int k = 0; k < NB; k++) begin
      mem_resp_valid = 1; mem_resp_data = DW'(k + 1);
      @(negedge clk);
      check("icrd_beat_route", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b10);
      check("icrd_in_rresp", o_dbg_state, RRESP);
      tick();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    check("icrd_back_to_arb", o_dbg_state, ARB);
    tick();

    // DC write alone
    wdat = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    a_valid[1] = 1; a_addr[1] = 28'h00000A0; a_rw[1] = 1;
    a_dv[1] = 1; a_data[1] = wdat; a_mask[1] = 16'hFFFF;
    mem_req_ready = 1; mem_req_data_ready = 0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("dcwr_req_ready", dc_mem_req_ready, 1);
    check("dcwr_req_addr", mem_req_addr, 28'h00000A0);
    tick();
    a_valid[1] = 0; mem_req_ready = 0;
    @(negedge clk);
    check("dcwr_dready_low", dc_mem_req_data_ready, 0);
    tick();
    mem_req_data_ready = 1;
    @(negedge clk);
    check("dcwr_dready_pulse", dc_mem_req_data_ready, 1);
    check("dcwr_bits", mem_req_data_bits, wdat);
    check("dcwr_mask", mem_req_data_mask, 16'hFFFF);
    tick();
    a_dv[1] = 0; mem_req_data_ready = 0;
    @(negedge clk);
    check("dcwr_dready_once", dc_mem_req_data_ready, 0);
    check("dcwr_back_to_arb", o_dbg_state, ARB);
    tick();

    // spurious response beats while idle
    mem_resp_valid = 1;
    for (int k = 0; k < 3; k++) begin
      mem_resp_data = rand_word();
      @(negedge clk);
      check("spur_resp_valid", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b00);
      check("spur_beat_cnt", o_dbg_beat_cnt, 0);
      tick();
    end
    mem_resp_valid = 0;

    // reset during a read after beat 1
    reset_dut();
    a_valid[0] = 1; a_addr[0] = 28'h0000040; a_rw[0] = 0; mem_req_ready = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    a_valid[0] = 0; mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = rand_word();
    tick();
    tick();
    check("rstmid_beat_before", o_dbg_beat_cnt, 2);
    #2 rst = 1;
    #1;
    check("rstmid_state", o_dbg_state, ARB);
    check("rstmid_beat", o_dbg_beat_cnt, 0);
    check("rstmid_hs", hs_now(), '0);
    tick();
    mem_resp_valid = 0;
    tick();
    rst = 0;
    a_valid[0] = 1; a_addr[0] = 28'h0000080; a_rw[0] = 0; mem_req_ready = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("rstmid_reread_ready", ic_mem_req_ready, 1);
    tick();
    a_valid[0] = 0; mem_req_ready = 0; mem_resp_valid = 1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      check("rstmid_reread_cnt", o_dbg_beat_cnt, k);
      tick();
    end
    mem_resp_valid = 0;
    @(negedge clk);
    check("rstmid_reread_done", o_dbg_state, ARB);

    // simultaneous requests, both holding valid across three grants
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_exp_dc = 3'b010;
`else
    tie_exp_dc = 3'b111;
`endif
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      a_valid[i] = 1; a_rw[i] = 1; a_dv[i] = 1; a_mask[i] = 16'h00FF;
      a_addr[i] = (i == 0) ? 28'h0000010 : 28'h1000010;
      a_data[i] = rand_word();
    end
    mem_req_ready = 1; mem_req_data_ready = 1;
    for (int i = 0; i < 3; i++) begin
      found = 0;
      c = 0;
      while (!found && c < 20) begin
        @(negedge clk);
        if (mem_req_valid) found = 1;
        else c++;
      end
      check("tie_grant_seen", found, 1);
      check("tie_winner_is_dc", dc_mem_req_ready, tie_exp_dc[i]);
      @(posedge clk);
      #1;
    end

    // randomized traffic from both caches
    reset_dut();
    mem_auto = 1;
    fork
      run_agent(0, 30);
      run_agent(1, 30);
    join
    mem_auto = 0;
    idle_all();
    repeat (3) tick();
    @(negedge clk);
    check("final_idle_state", o_dbg_state, ARB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
